// File: rtl/float_params.sv
// Shared single-precision float field widths.
// Used by every block that touches the FP datapath.
package float_params;
    localparam int float_width      = 32;
    localparam int float_exp_width  = 8;
    localparam int float_mant_width = 23;
endpackage

// File: rtl/float_add.sv
// Combinational IEEE-754 single-precision adder.
// Round-to-nearest-even, denormals kept, NaN/inf propagated.
module float_add
    import float_params::*;
(
    input  logic [float_width-1:0] a,
    input  logic [float_width-1:0] b,
    output logic [float_width-1:0] y
);
    localparam int MW = float_mant_width;
    localparam int EW = float_exp_width;
    localparam int XW = MW + 4;

    logic [float_width-1:0] big, sml;
    logic [EW-1:0]          eb, es, d;
    logic [XW-1:0]          xl, xs, smask, n;
    logic [XW:0]            s;
    logic [EW:0]            e;
    logic [4:0]             lz, sh;
    logic [float_width-2:0] mag;
    logic                   up;

    always_comb begin
        smask = '0;
        if (a[float_width-2:0] >= b[float_width-2:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        eb = (big[MW+:EW] == '0) ? EW'(1) : big[MW+:EW];
        es = (sml[MW+:EW] == '0) ? EW'(1) : sml[MW+:EW];
        d  = eb - es;
        xl = {|big[MW+:EW], big[MW-1:0], 3'b000};
        xs = {|sml[MW+:EW], sml[MW-1:0], 3'b000};
        // Bits shifted out of the small operand collapse into sticky
        if (d > EW'(XW - 1)) begin
            xs = {{(XW-1){1'b0}}, |xs};
        end else begin
            smask = ~({XW{1'b1}} << d);
            xs = (xs >> d) | {{(XW-1){1'b0}}, |(xs & smask)};
        end
        if (big[float_width-1] == sml[float_width-1])
            s = {1'b0, xl} + {1'b0, xs};
        else
            s = {1'b0, xl} - {1'b0, xs};
        lz = 5'(XW);
        for (int i = 0; i < XW; i++)
            if (s[i]) lz = 5'(XW - 1 - i);
        if (int'(lz) > int'(eb) - 1) sh = 5'(int'(eb) - 1);
        else sh = lz;
        if (s[XW]) begin
            n = s[XW:1] | {{(XW-1){1'b0}}, s[0]};
            e = {1'b0, eb} + (EW+1)'(1);
        end else begin
            n = s[XW-1:0] << sh;
            e = {1'b0, eb} - (EW+1)'(sh);
        end
        up  = n[2] & (n[1] | n[0] | n[3]);
        // Rounding carry ripples naturally into the exponent field
        mag = {(n[XW-1] ? e[EW-1:0] : {EW{1'b0}}), n[XW-2:3]}
            + (float_width-1)'(up);
        y = {big[float_width-1], mag};
        if (e >= (EW+1)'((1 << EW) - 1))
            y = {big[float_width-1], {EW{1'b1}}, {MW{1'b0}}};
        if (s == '0)
            y = {big[float_width-1] & sml[float_width-1],
                 {(float_width-1){1'b0}}};
        if (big[MW+:EW] == {EW{1'b1}}) begin
            if (big[MW-1:0] != '0 ||
                (sml[MW+:EW] == {EW{1'b1}} &&
                 sml[float_width-1] != big[float_width-1]))
                y = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
            else
                y = big;
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                gnt_idx = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/float_add_arbiter.sv
// Shares one float_add between NUM_REQ requesters with round-robin
// grants; operands and result are registered around the adder.
module float_add_arbiter
    import float_params::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int REQ_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*float_width-1:0] req_a,
    input  logic [NUM_REQ*float_width-1:0] req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [float_width-1:0]         rsp_out,
    output logic [REQ_ID_W-1:0]            rsp_id,
    output logic                           busy,
    output logic [CNT_W-1:0]               op_count
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t                 state, state_nxt;
    logic [REQ_ID_W-1:0]    rr_ptr, ptr_nxt, gnt_idx, op_id;
    logic [NUM_REQ-1:0]     gnt;
    logic [float_width-1:0] op_a, op_b, sum;
    logic                   accept_ok, hs;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (REQ_ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    float_add u_add (
        .a (op_a),
        .b (op_b),
        .y (sum)
    );

    always_comb begin
        // No grant may be offered while reset is held
        accept_ok = rst && ((state == IDLE) ||
                            (state == RESP && rsp_ready));
        hs        = accept_ok && (|req_valid);
        req_ready = accept_ok ? gnt : '0;
        ptr_nxt   = (int'(gnt_idx) == NUM_REQ - 1) ? '0
                  : gnt_idx + REQ_ID_W'(1);
        state_nxt = state;
        unique case (state)
            IDLE:    if (hs) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = hs ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_out   <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                op_a   <= req_a[int'(gnt_idx)*float_width +: float_width];
                op_b   <= req_b[int'(gnt_idx)*float_width +: float_width];
                op_id  <= gnt_idx;
                rr_ptr <= ptr_nxt;
            end
            if (state == CALC) begin
                rsp_out   <= sum;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + CNT_W'(1);
            end
        end
    end
endmodule
